serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle WIDTH-bit subtractor, the inverse operation of the lab's one-bit full adder.
- Loads minuend A, subtrahend B and a borrow-in on a start strobe.
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Presents the parallel difference and final borrow with a one-cycle done pulse; intended as the sequential datapath lab block alongside the combinational adder labs.

---
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. A start strobe accepted while idle
//   captures the minuend, subtrahend and borrow-in. Bits are then processed
//   LSB first through one full-subtractor cell and a borrow flop, one bit per
//   clock. The parallel difference and final borrow are published together
//   with a one-cycle done pulse.
//
// Ports
//   clock  in   rising-edge clock
//   rstn   in   asynchronous active-low reset
//   start  in   request strobe, sampled only when not busy
//   a      in   minuend    [WIDTH-1:0], captured on the accepted start edge
//   b      in   subtrahend [WIDTH-1:0], captured on the accepted start edge
//   bin    in   borrow-in, captured on the accepted start edge
//   diff   out  registered (a - b - bin) mod 2^WIDTH
//   bout   out  registered final borrow (1 when a < b + bin)
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when diff/bout have been updated
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtractor cell acting on the current LSBs and the borrow flop.
    logic bit_diff;
    logic bit_borrow;

    always_comb begin
        bit_diff   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        bit_borrow = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            // DONE accepts a new request exactly like IDLE so that a held
            // start gives back-to-back operations.
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    r_sh_d  = '0;
                    br_d    = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                busy_d = 1'b1;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = {bit_diff, r_sh_q[WIDTH-1:1]};
                br_d   = bit_borrow;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish the result including the bit computed this edge.
                    diff_d  = {bit_diff, r_sh_q[WIDTH-1:1]};
                    bout_d  = bit_borrow;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor with WIDTH=4.
//   Inputs are driven on the falling edge; outputs are sampled on the
//   falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clock;
    logic         rstn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int n_vec;
    int n_err;
    int done_cnt;

    serial_subtractor #(.WIDTH(W)) dut (
        .clock (clock),
        .rstn  (rstn),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: start driven for one cycle, then wait (bounded) for done.
    // When full=1 the latency, busy duration and post-done deassertion are checked.
    task automatic op(input logic [3:0] a_i, input logic [3:0] b_i, input logic bin_i,
                      input logic [3:0] ed, input logic eb, input bit full, input string tag);
        int lat;
        int busy_n;
        @(negedge clock);
        a = a_i; b = b_i; bin = bin_i; start = 1'b1;
        @(negedge clock);                 // first sample after the accepting edge
        start = 1'b0;
        lat = 0; busy_n = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clock);
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_result"}, {27'd0, bout, diff}, {27'd0, eb, ed});
        if (full) begin
            chk({tag, "_latency"}, 32'(lat), 32'd4);
            chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            @(negedge clock);
            chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, {27'd0, bout, diff}, {27'd0, eb, ed});
        end
    endtask

    initial begin
        int d0;
        logic [4:0] e;
        n_vec = 0; n_err = 0; done_cnt = 0;
        rstn = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        // Reset state
        #12;
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        rstn = 1'b1;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed cases
        op(4'd9,  4'd5,  1'b0, 4'd4,  1'b0, 1'b1, "9m5");
        op(4'd5,  4'd9,  1'b0, 4'd12, 1'b1, 1'b1, "5m9");
        op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b1, "0m0b1");
        op(4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b1, "15m15");

        // Exhaustive sweep against arithmetic reference
        d0 = done_cnt;
        for (int unsigned ai = 0; ai < 16; ai++) begin
            for (int unsigned bi = 0; bi < 16; bi++) begin
                for (int unsigned ci = 0; ci < 2; ci++) begin
                    e = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - {4'd0, 1'(ci)};
                    op(4'(ai), 4'(bi), 1'(ci), e[3:0], e[4], 1'b0, "sweep");
                end
            end
        end
        @(negedge clock);
        chk("sweep_done_count", 32'(done_cnt - d0), 32'd512);

        // Start while busy is ignored
        d0 = done_cnt;
        @(negedge clock);
        a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        a = 4'd1; b = 4'd1; start = 1'b1;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        chk("ign_result", {27'd0, bout, diff}, {27'd0, 1'b0, 4'd4});
        chk("ign_one_done", 32'(done_cnt - d0), 32'd1);
        chk("ign_idle", 32'(busy), 32'd0);

        // Reset asserted in the second SHIFT cycle
        d0 = done_cnt;
        @(negedge clock);
        a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        rstn = 1'b0;
        #1;
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clock);
        rstn = 1'b1;
        repeat (8) @(negedge clock);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_still_zero", {27'd0, bout, diff}, 32'd0);
        op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b1, "7m2");

        // Start held high: back-to-back operations every WIDTH+1 cycles
        @(negedge clock);
        a = 4'd3; b = 4'd1; bin = 1'b0; start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            chk("b2b_done", 32'(done), ((i % 5) == 4) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(busy), ((i % 5) == 4) ? 32'd0 : 32'd1);
            if ((i % 5) == 4)
                chk("b2b_result", {27'd0, bout, diff}, {27'd0, 1'b0, 4'd2});
        end
        start = 1'b0;
        @(negedge clock);
        chk("b2b_stop_busy", 32'(busy), 32'd0);
        chk("b2b_stop_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
